sync_filt: RTL and testbench

- Multi-channel synchronizer, the parametrised successor to the team's N-flip-flop synchronizer.
- Each of P_NCH asynchronous inputs passes through an N-stage synchronizer chain, then a consecutive-sample deglitch filter.
- Emits the filtered level plus one-cycle rise/fall pulses per channel.
- Used on board-level status lines (button, PG, alarm pins) feeding control logic in the clk domain.

---
 rtl/sync_filt.sv | 97 +++++++++
 tb/tb_sync_filt.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sync_filt.sv
// Multi-channel input conditioner: N-flop synchronizer, consecutive-sample deglitch filter,
// registered rise/fall pulses. Optional sticky event flags when SYNC_FILT_STICKY_EN is defined.
module sync_filt #(
  parameter int               P_NCH    = 8,
  parameter int               P_NFF    = 2,
  parameter int               P_NFILT  = 4,
  parameter logic [P_NCH-1:0] P_DEFVAL = {P_NCH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [P_NCH-1:0] a,
  output logic [P_NCH-1:0] y,
  output logic [P_NCH-1:0] rise,
  output logic [P_NCH-1:0] fall
`ifdef SYNC_FILT_STICKY_EN
  ,
  input  logic [P_NCH-1:0] clr,
  output logic [P_NCH-1:0] sticky
`endif
);

  localparam int NFF   = (P_NFF < 2) ? 2 : P_NFF;
  localparam int NFILT = (P_NFILT < 1) ? 1 : P_NFILT;
  localparam int CW    = $clog2(NFILT + 1);

  (* ASYNC_REG = "TRUE" *) logic [NFF-1:0][P_NCH-1:0] sync_r;

  logic [P_NCH-1:0]         s_s;
  logic [P_NCH-1:0][CW-1:0] cnt_r;
  logic [P_NCH-1:0][CW-1:0] cnt_nxt_s;
  logic [P_NCH-1:0]         upd_s;
  logic [P_NCH-1:0]         y_r;
  logic [P_NCH-1:0]         rise_r;
  logic [P_NCH-1:0]         fall_r;

  assign s_s = sync_r[NFF-1];

  // Synchronizer shift chain, stage 0 samples the raw inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= {NFF{P_DEFVAL}};
    end else begin
      sync_r <= {sync_r[NFF-2:0], a};
    end
  end

  // Per-channel run counter; a matching sample restarts the run.
  always_comb begin
    cnt_nxt_s = '0;
    upd_s     = '0;
    for (int i = 0; i < P_NCH; i++) begin
      if (s_s[i] == y_r[i]) begin
        cnt_nxt_s[i] = '0;
      end else if (cnt_r[i] == CW'(NFILT - 1)) begin
        upd_s[i]     = 1'b1;
        cnt_nxt_s[i] = '0;
      end else begin
        cnt_nxt_s[i] = cnt_r[i] + CW'(1);
      end
    end
  end

  // Filter state and edge pulses, all updated on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r  <= '0;
      y_r    <= P_DEFVAL;
      rise_r <= '0;
      fall_r <= '0;
    end else begin
      cnt_r  <= cnt_nxt_s;
      y_r    <= y_r ^ upd_s;
      rise_r <= ~y_r & s_s & upd_s;
      fall_r <= y_r & ~s_s & upd_s;
    end
  end

  assign y    = y_r;
  assign rise = rise_r;
  assign fall = fall_r;

`ifdef SYNC_FILT_STICKY_EN
  logic [P_NCH-1:0] sticky_r;

  // Event latch: a pulse seen this cycle overrides a clear on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_r <= '0;
    end else begin
      sticky_r <= (sticky_r & ~clr) | rise_r | fall_r;
    end
  end

  assign sticky = sticky_r;
`endif

endmodule

// File: tb/tb_sync_filt.sv
// Randomized self-checking bench for sync_filt: two configurations (nominal and clamped
// minimum) compared every cycle against a sliding-window reference model.
module tb_sync_filt;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] a;
  logic [3:0] clr;
  logic [3:0] y0, r0, f0, y1, r1, f1;
`ifdef SYNC_FILT_STICKY_EN
  logic [3:0] st0, st1;
`endif

  int checks = 0;
  int fails  = 0;
  int n_r0   = 0;
  int n_f0   = 0;

  always #5 clk = ~clk;

  sync_filt #(.P_NCH(4), .P_NFF(2), .P_NFILT(4), .P_DEFVAL(4'b0000)) dut0 (
    .clk(clk), .rst_n(rst_n), .a(a), .y(y0), .rise(r0), .fall(f0)
`ifdef SYNC_FILT_STICKY_EN
    , .clr(clr), .sticky(st0)
`endif
  );

  sync_filt #(.P_NCH(4), .P_NFF(1), .P_NFILT(0), .P_DEFVAL(4'b0001)) dut1 (
    .clk(clk), .rst_n(rst_n), .a(a), .y(y1), .rise(r1), .fall(f1)
`ifdef SYNC_FILT_STICKY_EN
    , .clr(clr), .sticky(st1)
`endif
  );

  // Reference model: y flips once the last NFILT synchronized samples all disagree with it.
  logic [3:0] m_samp   [2][2];
  logic [3:0] m_win    [2][4];
  logic [3:0] m_y      [2];
  logic [3:0] m_rise   [2];
  logic [3:0] m_fall   [2];
  logic [3:0] m_sticky [2];

  function automatic int cfg_nfilt(input int c);
    return (c == 0) ? 4 : 1;
  endfunction

  function automatic logic [3:0] cfg_def(input int c);
    return (c == 0) ? 4'b0000 : 4'b0001;
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < 2; k++) m_samp[c][k] = cfg_def(c);
      for (int k = 0; k < 4; k++) m_win[c][k] = cfg_def(c);
      m_y[c]      = cfg_def(c);
      m_rise[c]   = 4'b0000;
      m_fall[c]   = 4'b0000;
      m_sticky[c] = 4'b0000;
    end
  endtask

  task automatic model_step();
    logic [3:0] s;
    logic [3:0] flip;
    for (int c = 0; c < 2; c++) begin
      s = m_samp[c][1];
      for (int k = 3; k > 0; k--) m_win[c][k] = m_win[c][k-1];
      m_win[c][0] = s;
      flip = 4'b1111;
      for (int k = 0; k < cfg_nfilt(c); k++) flip = flip & (m_win[c][k] ^ m_y[c]);
      m_sticky[c] = (m_sticky[c] & ~clr) | m_rise[c] | m_fall[c];
      m_rise[c]   = flip & ~m_y[c];
      m_fall[c]   = flip & m_y[c];
      m_y[c]      = m_y[c] ^ flip;
      m_samp[c][1] = m_samp[c][0];
      m_samp[c][0] = a;
    end
  endtask

  task automatic compare_all();
    chk("y0", y0, m_y[0]);
    chk("rise0", r0, m_rise[0]);
    chk("fall0", f0, m_fall[0]);
    chk("y1", y1, m_y[1]);
    chk("rise1", r1, m_rise[1]);
    chk("fall1", f1, m_fall[1]);
    chk("rf_excl0", r0 & f0, 4'b0000);
`ifdef SYNC_FILT_STICKY_EN
    chk("sticky0", st0, m_sticky[0]);
    chk("sticky1", st1, m_sticky[1]);
`endif
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
    n_r0 += int'(r0[0]);
    n_f0 += int'(f0[0]);
  endtask

  // Asserts reset between edges and checks that outputs clear without a clock edge.
  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    chk({tag, "_y0"}, y0, 4'b0000);
    chk({tag, "_y1"}, y1, 4'b0001);
    chk({tag, "_rf0"}, r0 | f0, 4'b0000);
    chk({tag, "_rf1"}, r1 | f1, 4'b0000);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    a     = 4'b1010;
    clr   = 4'b0000;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_y0", y0, 4'b0000);
    chk("rst_y1", y1, 4'b0001);
    chk("rst_rf0", r0 | f0, 4'b0000);
    chk("rst_rf1", r1 | f1, 4'b0000);
    rst_n = 1'b1;

    // Startup with a held away from the reset value.
    for (int e = 1; e <= 7; e++) begin
      cycle();
      if (e == 3) begin
        chk("min_y_e3", y1, 4'b1010);
        chk("min_fall_e3", f1, 4'b0001);
      end
      if (e == 5) chk("start_y_e5", y0, 4'b0000);
      if (e == 6) begin
        chk("start_y_e6", y0, 4'b1010);
        chk("start_rise_e6", r0, 4'b1010);
        chk("start_fall_e6", f0, 4'b0000);
      end
      if (e == 7) chk("start_rise_e7", r0, 4'b0000);
    end

    // Glitch of 3 cycles on ch0 must be rejected.
    a = 4'b0000;
    repeat (12) cycle();
    n_r0 = 0; n_f0 = 0;
    a[0] = 1'b1;
    repeat (3) cycle();
    a[0] = 1'b0;
    repeat (10) cycle();
    chk("glitch_y", {3'b000, y0[0]}, 4'b0000);
    chk("glitch_nr", 4'(n_r0), 4'd0);
    chk("glitch_nf", 4'(n_f0), 4'd0);

    // Pulse of exactly 4 cycles on ch0 passes once.
    n_r0 = 0; n_f0 = 0;
    a[0] = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      cycle();
    end
    a[0] = 1'b0;
    for (int e = 5; e <= 14; e++) begin
      cycle();
      if (e == 6)  chk("thr_rise_e6", {3'b000, r0[0]}, 4'b0001);
      if (e == 10) chk("thr_fall_e10", {3'b000, f0[0]}, 4'b0001);
    end
    chk("thr_nr", 4'(n_r0), 4'd1);
    chk("thr_nf", 4'(n_f0), 4'd1);

    // Reset in the middle of a count on ch2.
    a[2] = 1'b1;
    repeat (4) cycle();
    async_reset("midcnt");
    a = 4'b0000;
    n_r0 = 0; n_f0 = 0;
    repeat (10) cycle();
    chk("midcnt_nr", 4'(n_r0), 4'd0);
    chk("midcnt_nf", 4'(n_f0), 4'd0);

`ifdef SYNC_FILT_STICKY_EN
    a[1] = 1'b1;
    repeat (8) cycle();
    chk("sticky_set", {3'b000, st0[1]}, 4'b0001);
    repeat (10) cycle();
    clr[1] = 1'b1;
    cycle();
    clr[1] = 1'b0;
    chk("sticky_clr", {3'b000, st0[1]}, 4'b0000);
    a[1] = 1'b0;
    repeat (8) cycle();
    clr[1] = 1'b1;
    a[1]   = 1'b1;
    for (int e = 0; e < 12; e++) begin
      cycle();
      if (m_rise[0][1]) break;
    end
    chk("sticky_pre", {3'b000, r0[1]}, 4'b0001);
    cycle();
    chk("sticky_setwins", {3'b000, st0[1]}, 4'b0001);
    clr[1] = 1'b0;
`endif

    // Randomized runs of varying length, random clears and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 5) == 0) a[i] = ~a[i];
        clr[i] = ($urandom_range(0, 7) == 0);
      end
      if ($urandom_range(0, 399) == 0) async_reset("rnd_rst");
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
